// File: rtl/cache_mem_pkg.sv
// Definitions shared by the caches and the memory-port arbiter:
// FSM states, grant codes and cache-line geometry.
package cache_mem_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  typedef enum logic {GNT_IC, GNT_DC} grant_t;

  localparam int MEM_DATA_W = 32;
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = $clog2(LINE_WORDS * MEM_DATA_W / 8);
  localparam int BEAT_W     = $clog2(LINE_WORDS);
  localparam int BYTE_W     = OFFSET_W - BEAT_W;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Cache-side and memory-side signals of the shared memory port.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = cache_mem_pkg::MEM_DATA_W
);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_data;
  logic              ic_valid;
  logic              ic_done;
  logic              dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic              dc_we;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_data;
  logic              dc_valid;
  logic              dc_done;
  logic              mem_request;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              memory_ready;
  logic [DATA_W-1:0] memory_data;

  // The arbiter is the slave of both caches and drives the memory model.
  modport slave (
    input  ic_req, ic_addr, dc_req, dc_addr, dc_we, dc_wdata, memory_ready, memory_data,
    output ic_data, ic_valid, ic_done, dc_data, dc_valid, dc_done,
    output mem_request, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_addr, dc_we, dc_wdata, memory_ready, memory_data,
    input  ic_data, ic_valid, ic_done, dc_data, dc_valid, dc_done,
    input  mem_request, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick; the requester that did not win last time wins a tie.
module rr_arb2
  import cache_mem_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
  input  grant_t last_grant,
  output logic   any_req,
  output grant_t pick
);

  assign any_req = ic_req | dc_req;

  always_comb begin
    pick = GNT_DC;
    if (ic_req && (!dc_req || last_grant == GNT_DC))
      pick = GNT_IC;
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one memory port between I-cache line refills and D-cache line reads
// or single-word writes; every output is registered.
module imem_port_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  imem_port_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << BYTE_W) - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  state_t            state;
  grant_t            last_grant;
  grant_t            pick;
  logic              any_req;
  logic              txn_we;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] next_beat;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              last_beat;

  rr_arb2 u_rr_arb2 (
    .ic_req     (bus.ic_req),
    .dc_req     (bus.dc_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .pick       (pick)
  );

  assign sel_addr  = (pick == GNT_IC) ? bus.ic_addr : bus.dc_addr;
  assign sel_we    = (pick == GNT_DC) && bus.dc_we;
  assign next_beat = beat_cnt + BEAT_W'(1);
  assign last_beat = txn_we || (beat_cnt == BEAT_W'(LINE_WORDS - 1));

  // last_grant doubles as the owner of the burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      last_grant      <= GNT_DC;
      txn_we          <= 1'b0;
      line_base       <= '0;
      bus.mem_request <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_wdata   <= ZERO_WORD;
      bus.ic_data     <= ZERO_WORD;
      bus.ic_valid    <= 1'b0;
      bus.ic_done     <= 1'b0;
      bus.dc_data     <= ZERO_WORD;
      bus.dc_valid    <= 1'b0;
      bus.dc_done     <= 1'b0;
    end else begin
      bus.ic_valid <= 1'b0;
      bus.ic_done  <= 1'b0;
      bus.dc_valid <= 1'b0;
      bus.dc_done  <= 1'b0;
      bus.ic_data  <= ZERO_WORD;
      bus.dc_data  <= ZERO_WORD;
      case (state)
        IDLE: begin
          if (any_req) begin
            state           <= BURST;
            last_grant      <= pick;
            txn_we          <= sel_we;
            beat_cnt        <= '0;
            line_base       <= sel_addr & LINE_MASK;
            bus.mem_request <= 1'b1;
            bus.mem_we      <= sel_we;
            bus.mem_wdata   <= sel_we ? bus.dc_wdata : ZERO_WORD;
            bus.mem_addr    <= sel_we ? (sel_addr & WORD_MASK) : (sel_addr & LINE_MASK);
          end
        end
        BURST: begin
          if (bus.memory_ready) begin
            if (!txn_we) begin
              if (last_grant == GNT_IC) begin
                bus.ic_valid <= 1'b1;
                bus.ic_data  <= bus.memory_data;
              end else begin
                bus.dc_valid <= 1'b1;
                bus.dc_data  <= bus.memory_data;
              end
            end
            // Done rises together with the final valid, never a cycle later.
            if (last_beat) begin
              state           <= DONE;
              beat_cnt        <= '0;
              bus.mem_request <= 1'b0;
              bus.mem_addr    <= '0;
              bus.mem_we      <= 1'b0;
              bus.mem_wdata   <= ZERO_WORD;
              if (last_grant == GNT_IC)
                bus.ic_done <= 1'b1;
              else
                bus.dc_done <= 1'b1;
            end else begin
              beat_cnt     <= next_beat;
              bus.mem_addr <= line_base | (ADDR_W'(next_beat) << BYTE_W);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
